// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_pkg
//  Purpose  : Shared types and truth-table constants for the gate BIST engine.
//  Revision : 1.0  initial release
// ============================================================================
package gate_bist_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int VEC_W = 2;

   // Bit index of each table is the applied vector {a,b}
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/gate_bist_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_settle_timer
//  Purpose  : Load/count-down timer with a zero flag for the settle interval.
//  Revision : 1.0  initial release
// ============================================================================
module gate_bist_settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   // Loading N-1 lets the zero flag mark the last of N settle cycles
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist
//  Purpose  : Self-test engine that walks all four vectors of a 2-input gate.
//  Revision : 1.0  initial release
// ============================================================================
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [3:0] EXPECTED_TT   = TT_NAND
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic       fail_valid,
   output logic [1:0] fail_vec
);

   localparam logic [VEC_W-1:0] VEC_LAST = '1;

   state_t           state;
   state_t           state_nxt;
   logic [VEC_W-1:0] vec;
   logic             timer_load;
   logic             timer_dec;
   logic             timer_zero;
   logic             mismatch;
   logic [2:0]       err_next;

   gate_bist_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .dec  (timer_dec),
      .zero (timer_zero)
   );

   // Case inequality makes an unknown gate output count as a failure
   assign mismatch = (dut_y !== EXPECTED_TT[vec]);
   assign err_next = err_count + 3'(mismatch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            timer_load = 1'b1;
            state_nxt  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
         end
         SETTLE: begin
            if (timer_zero) begin
               state_nxt = CHECK;
            end else begin
               timer_dec = 1'b1;
            end
         end
         CHECK: begin
            state_nxt = (vec == VEC_LAST) ? DONE : APPLY;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec        <= '0;
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
         err_count  <= 3'd0;
         fail_valid <= 1'b0;
         fail_vec   <= 2'd0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vec        <= '0;
                  err_count  <= 3'd0;
                  fail_valid <= 1'b0;
                  fail_vec   <= 2'd0;
                  pass       <= 1'b0;
               end
            end
            APPLY: begin
               {dut_a, dut_b} <= vec;
            end
            CHECK: begin
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_vec   <= vec;
               end
               // Verdict is registered here so it is already valid while done is high
               if (vec == VEC_LAST) begin
                  pass <= (err_next == 3'd0);
               end else begin
                  vec <= vec + VEC_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
   assign done = (state == DONE);

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && (state == CHECK)) begin
         assert (!$isunknown(dut_y));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_bist
//  Purpose  : Scoreboard bench for gate_bist over several settle/table setups.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_bist;

   localparam int N = 4;
   // Instance setups: 0 = S2/NAND, 1 = S0/NAND, 2 = S1/NAND, 3 = S3/XOR
   localparam logic [15:0] S_PACK  = {4'd3, 4'd1, 4'd0, 4'd2};
   localparam logic [15:0] TT_PACK = {4'b0110, 4'b0111, 4'b0111, 4'b0111};

   typedef struct {
      int id;
      int t_start;
      int t_done;
      bit pass;
      int errs;
      bit fv;
      int fvec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start      [N];
   logic       dut_a      [N];
   logic       dut_b      [N];
   logic       dut_y      [N];
   logic       busy       [N];
   logic       done       [N];
   logic       pass       [N];
   logic [2:0] err_count  [N];
   logic       fail_valid [N];
   logic [1:0] fail_vec   [N];

   // Gate behaviour per instance: 0 NAND, 1 stuck-1, 2 AND (~NAND), 3 NAND delayed 1 cycle, 4 XOR
   int   mode      [N];
   exp_t sb[$];
   int   rd        = 0;
   int   cyc       = 0;
   int   next_free [N] = '{default: 0};
   int   last_vec  [N] = '{default: 0};
   int   checks    = 0;
   int   errors    = 0;
   int   zero_req  = 0;
   int   zero_seen = 0;

   function automatic logic gate_out(int m, logic a, logic b, logic d);
      case (m)
         0:       return ~(a & b);
         1:       return 1'b1;
         2:       return a & b;
         3:       return d;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int s_of(int i);
      return int'(S_PACK[i*4 +: 4]);
   endfunction

   function automatic logic [3:0] tt_of(int i);
      return TT_PACK[i*4 +: 4];
   endfunction

   // Gate output seen at the check of vector v; a delayed gate with no settle time still shows the previous vector
   function automatic bit ref_y(int m, int v, int s, int prev);
      int seen;
      case (m)
         0:       return v != 3;
         1:       return 1'b1;
         2:       return v == 3;
         3: begin
            seen = (s > 0) ? v : ((v == 0) ? prev : v - 1);
            return seen != 3;
         end
         default: return (v == 1) || (v == 2);
      endcase
   endfunction

   function automatic exp_t build_exp(int i, int t);
      exp_t       e;
      int         s;
      logic [3:0] tt;
      s         = s_of(i);
      tt        = tt_of(i);
      e.id      = i;
      e.t_start = t;
      e.t_done  = t + 1 + 4 * (s + 2);
      e.errs    = 0;
      e.fv      = 1'b0;
      e.fvec    = 0;
      for (int v = 0; v < 4; v++) begin
         if (ref_y(mode[i], v, s, last_vec[i]) != tt[v]) begin
            e.errs++;
            if (!e.fv) begin
               e.fv   = 1'b1;
               e.fvec = v;
            end
         end
      end
      e.pass = (e.errs == 0);
      return e;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: actual %0h, required %0h at cycle %0d", name, idx, act, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      logic y_dly;

      gate_bist #(
         .SETTLE_CYCLES (int'(S_PACK[gi*4 +: 4])),
         .EXPECTED_TT   (TT_PACK[gi*4 +: 4])
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[gi]),
         .dut_a      (dut_a[gi]),
         .dut_b      (dut_b[gi]),
         .dut_y      (dut_y[gi]),
         .busy       (busy[gi]),
         .done       (done[gi]),
         .pass       (pass[gi]),
         .err_count  (err_count[gi]),
         .fail_valid (fail_valid[gi]),
         .fail_vec   (fail_vec[gi])
      );

      always @(posedge clk) y_dly <= ~(dut_a[gi] & dut_b[gi]);
      assign dut_y[gi] = gate_out(mode[gi], dut_a[gi], dut_b[gi], y_dly);
   end

   initial forever #5 clk = ~clk;

   // Reference model: an idle engine accepts start and finishes a fixed number of cycles later
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         for (int i = 0; i < N; i++) begin
            next_free[i] = 0;
            last_vec[i]  = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (start[i] === 1'b1 && cyc >= next_free[i]) begin
               sb.push_back(build_exp(i, cyc));
               next_free[i] = sb[sb.size()-1].t_done + 1;
               last_vec[i]  = 3;
            end
         end
      end
      cyc = cyc + 1;
   end

   // Monitor
   always @(negedge clk) begin : mon
      bit   be;
      exp_t e;
      if (zero_req != zero_seen) begin
         zero_seen = zero_req;
         for (int i = 0; i < N; i++) begin
            chk("rst_busy",       i, busy[i],       0);
            chk("rst_done",       i, done[i],       0);
            chk("rst_pass",       i, pass[i],       0);
            chk("rst_err_count",  i, err_count[i],  0);
            chk("rst_fail_valid", i, fail_valid[i], 0);
            chk("rst_fail_vec",   i, fail_vec[i],   0);
            chk("rst_dut_a",      i, dut_a[i],      0);
            chk("rst_dut_b",      i, dut_b[i],      0);
         end
      end
      for (int i = 0; i < N; i++) begin
         be = (rd < sb.size()) && (sb[rd].id == i) && (cyc > sb[rd].t_start) && (cyc < sb[rd].t_done);
         chk("busy", i, busy[i], be);
         if (done[i] === 1'b1) begin
            if (rd >= sb.size() || sb[rd].id != i) begin
               chk("unexpected_done", i, done[i], 0);
            end else begin
               e = sb[rd];
               rd++;
               chk("done_cycle", i, cyc, e.t_done);
               chk("pass", i, pass[i], e.pass);
               chk("err_count", i, err_count[i], e.errs);
               chk("fail_valid", i, fail_valid[i], e.fv);
               if (e.fv) chk("fail_vec", i, fail_vec[i], e.fvec);
            end
         end
      end
      if (rd < sb.size() && cyc > sb[rd].t_done) begin
         chk("done_timeout", sb[rd].id, cyc, sb[rd].t_done);
         rd++;
      end
      if (rst === 1'b1) rd = sb.size();
   end

   task automatic pulse(input int i);
      @(posedge clk);
      #1 start[i] = 1'b1;
      @(posedge clk);
      #1 start[i] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && rd < sb.size(); k++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0;
         mode[i]  = 0;
      end
      repeat (2) @(posedge clk);
      #1 zero_req++;
      @(posedge clk);
      #1 rst = 1'b0;

      // Good NAND, faulty stuck-1, inverted gate with no settle time
      pulse(0); drain();
      mode[0] = 1; pulse(0); drain();
      mode[1] = 2; pulse(1); drain();

      // Reset during the settle of vector 10, then a clean run
      mode[0] = 0;
      pulse(0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 zero_req++;
      @(posedge clk);
      #1 rst = 1'b0;
      pulse(0); drain();

      // Ignored start while busy, then start held across DONE with a gate change
      pulse(0);
      repeat (4) @(posedge clk);
      pulse(0);
      repeat (3) @(posedge clk);
      #1 start[0] = 1'b1;
      for (int k = 0; k < 100 && done[0] !== 1'b1; k++) @(negedge clk);
      mode[0] = 1;
      @(posedge clk);
      @(posedge clk);
      #1 start[0] = 1'b0;
      drain();

      // Slow gate with and without settle time
      mode[2] = 3; pulse(2); drain();
      mode[1] = 0; pulse(1); drain();
      mode[1] = 3; pulse(1); drain();

      for (int it = 0; it < 40; it++) begin
         int i;
         i       = int'($urandom_range(0, N - 1));
         mode[i] = int'($urandom_range(0, 4));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         pulse(i);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            pulse(i);
         end
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, actual running, required finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
